cksum_dispatch: RTL and testbench

- Job front-end that sits directly upstream of the checksum unit.
- Accepts checksum job descriptors (field start, field length, destination address) over a valid/ready interface and buffers them in a small FIFO.
- Runs the checksum unit's level start/ready handshake one job at a time.
- Reports per-job completion and a running completion count to the pipeline controller.

---
 rtl/cksum_dispatch_pkg.sv | 27 ++
 rtl/cksum_dispatch_if.sv | 37 +++
 rtl/cksum_dispatch_job_fifo.sv | 65 ++++++
 rtl/cksum_dispatch.sv | 163 ++++++++++++++++
 tb/tb_cksum_dispatch.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cksum_dispatch_pkg.sv
// Shared types for the checksum job dispatcher: FSM state encoding, the job
// descriptor layout and the bus widths it is built on.
package cksum_pkg;

  localparam int CKSUM_ADDR_W = 32;
  localparam int CKSUM_DATA_W = 32;
  localparam int CKSUM_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } cksum_state_e;

  typedef struct packed {
    logic [CKSUM_ADDR_W-1:0] field_start;
    logic [CKSUM_DATA_W-1:0] field_len;
    logic [CKSUM_ADDR_W-1:0] dst;
  } cksum_job_t;

  // Occupancy counter width for a FIFO holding 0..depth entries.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cksum_dispatch_if.sv
// Job descriptor intake and checksum-unit handshake bundle. The slave modport is
// the dispatcher's view; master is the surrounding pipeline/checksum side.
interface cksum_dispatch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              job_valid_i;
  logic              job_ready_o;
  logic [ADDR_W-1:0] job_field_start_i;
  logic [DATA_W-1:0] job_field_len_i;
  logic [ADDR_W-1:0] job_dst_i;

  logic              cks_start_o;
  logic [ADDR_W-1:0] cks_field_start_o;
  logic [DATA_W-1:0] cks_field_len_o;
  logic [ADDR_W-1:0] cks_dst_o;
  logic              cks_ready_i;

  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  jobs_done_o;
  logic              err_o;

  modport slave (
    input  job_valid_i, job_field_start_i, job_field_len_i, job_dst_i, cks_ready_i,
    output job_ready_o, cks_start_o, cks_field_start_o, cks_field_len_o, cks_dst_o,
    output busy_o, done_o, jobs_done_o, err_o
  );

  modport master (
    output job_valid_i, job_field_start_i, job_field_len_i, job_dst_i, cks_ready_i,
    input  job_ready_o, cks_start_o, cks_field_start_o, cks_field_len_o, cks_dst_o,
    input  busy_o, done_o, jobs_done_o, err_o
  );

endinterface

// File: rtl/cksum_dispatch_job_fifo.sv
// Synchronous descriptor FIFO. The head entry is presented combinationally; the
// dispatcher's output register captures it on pop, acting as the registered read.
module job_fifo
  import cksum_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  cksum_job_t                     push_data,
  input  logic                           pop,
  output cksum_job_t                     pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cksum_job_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth: pointers wrap naturally at their full width.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cksum_dispatch.sv
// Checksum job front-end: queues descriptors and runs the checksum unit's level
// start/ready handshake one job at a time. Optional WAIT timeout: CKSUM_DISPATCH_TIMEOUT_EN.
module cksum_dispatch
  import cksum_pkg::*;
#(
  parameter int ADDR_W         = CKSUM_ADDR_W,
  parameter int DATA_W         = CKSUM_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = CKSUM_CNT_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst,
  cksum_dispatch_if.slave bus
);

  localparam int FCNT_W = fifo_cnt_w(FIFO_DEPTH);

  // Elaboration-time guards: the descriptor struct is sized by the package.
  if (ADDR_W != CKSUM_ADDR_W || DATA_W != CKSUM_DATA_W) begin : g_bad_width
    $error("cksum_dispatch: ADDR_W/DATA_W must match cksum_pkg widths");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cksum_dispatch: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cksum_dispatch: TIMEOUT_CYCLES must be at least 1");
  end

  cksum_state_e      state_reg, state_next;
  cksum_job_t        job_reg, job_next;
  logic              cks_start_reg, cks_start_next;
  logic              done_reg, done_next;
  logic [CNT_W-1:0]  jobs_done_reg, jobs_done_next;

  cksum_job_t        fifo_push_data;
  cksum_job_t        fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

`ifdef CKSUM_DISPATCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic              err_reg, err_next;
`endif

  assign fifo_push      = bus.job_valid_i && !fifo_full;
  assign fifo_push_data = '{field_start: bus.job_field_start_i,
                            field_len:   bus.job_field_len_i,
                            dst:         bus.job_dst_i};

  job_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_job_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      job_reg       <= '0;
      cks_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      jobs_done_reg <= '0;
`ifdef CKSUM_DISPATCH_TIMEOUT_EN
      tmo_reg       <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      job_reg       <= job_next;
      cks_start_reg <= cks_start_next;
      done_reg      <= done_next;
      jobs_done_reg <= jobs_done_next;
`ifdef CKSUM_DISPATCH_TIMEOUT_EN
      tmo_reg       <= tmo_next;
      err_reg       <= err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    job_next       = job_reg;
    cks_start_next = cks_start_reg;
    done_next      = 1'b0;
    jobs_done_next = jobs_done_reg;
    fifo_pop       = 1'b0;
`ifdef CKSUM_DISPATCH_TIMEOUT_EN
    tmo_next       = tmo_reg;
    err_next       = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        // The only place the cks_* payload may change, so it is stable under start.
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          job_next       = fifo_head;
          cks_start_next = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        // cks_ready_i may still be high from the previous job here; ignore it.
        state_next = WAIT;
`ifdef CKSUM_DISPATCH_TIMEOUT_EN
        tmo_next   = '0;
`endif
      end
      WAIT: begin
        if (bus.cks_ready_i) begin
          cks_start_next = 1'b0;
          done_next      = 1'b1;
          jobs_done_next = jobs_done_reg + CNT_W'(1);
          state_next     = RELEASE;
        end
`ifdef CKSUM_DISPATCH_TIMEOUT_EN
        else if (tmo_reg == TMO_LAST) begin
          cks_start_next = 1'b0;
          err_next       = 1'b1;
          state_next     = RELEASE;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
`endif
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.job_ready_o       = !fifo_full;
  assign bus.cks_start_o       = cks_start_reg;
  assign bus.cks_field_start_o = job_reg.field_start;
  assign bus.cks_field_len_o   = job_reg.field_len;
  assign bus.cks_dst_o         = job_reg.dst;
  assign bus.busy_o            = (fifo_count != '0) || (state_reg != IDLE);
  assign bus.done_o            = done_reg;
  assign bus.jobs_done_o       = jobs_done_reg;
`ifdef CKSUM_DISPATCH_TIMEOUT_EN
  assign bus.err_o             = err_reg;
`else
  assign bus.err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_cksum_dispatch.sv
// Directed self-checking bench for cksum_dispatch; the testbench plays both the
// descriptor source and the checksum unit.
module tb_cksum_dispatch;
  import cksum_pkg::*;

`ifdef CKSUM_DISPATCH_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0;
  logic exp_err = 1'b0;

  cksum_dispatch_if bus ();

  cksum_dispatch #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .CNT_W(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input logic [31:0] fs, input logic [31:0] fl, input logic [31:0] d);
    bus.job_field_start_i = fs;
    bus.job_field_len_i   = fl;
    bus.job_dst_i         = d;
  endtask

  task automatic push(input logic [31:0] fs, input logic [31:0] fl, input logic [31:0] d);
    set_job(fs, fl, d);
    bus.job_valid_i = 1'b1;
    step();
    bus.job_valid_i = 1'b0;
  endtask

  task automatic check_cks(input string tag, input logic [31:0] fs, input logic [31:0] fl,
                           input logic [31:0] d);
    check1 ({tag, "_start"}, bus.cks_start_o, 1'b1);
    check32({tag, "_fs"}, bus.cks_field_start_o, fs);
    check32({tag, "_len"}, bus.cks_field_len_o, fl);
    check32({tag, "_dst"}, bus.cks_dst_o, d);
    $display("job %s start=%b fs=0x%0h len=%0d dst=0x%0h", tag, bus.cks_start_o,
             bus.cks_field_start_o, bus.cks_field_len_o, bus.cks_dst_o);
  endtask

  // Steps until cks_start_o is high; running out of budget is a failed check.
  task automatic wait_start(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (bus.cks_start_o !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    check1({tag, "_wait_start"}, bus.cks_start_o, 1'b1);
  endtask

  // Unit raises ready for one edge while in WAIT; expect a counted completion.
  task automatic complete(input string tag);
    bus.cks_ready_i = 1'b1;
    step();
    exp_done++;
    check1 ({tag, "_done"}, bus.done_o, 1'b1);
    check1 ({tag, "_start_low"}, bus.cks_start_o, 1'b0);
    check32({tag, "_count"}, 32'(bus.jobs_done_o), 32'(exp_done));
    $display("job %s done=%b jobs_done=%0d", tag, bus.done_o, bus.jobs_done_o);
    bus.cks_ready_i = 1'b0;
  endtask

  logic [31:0] jfs [5];
  logic [31:0] jfl [5];
  logic [31:0] jdst[5];
  int          cyc;

  initial begin
    bus.job_valid_i = 1'b0;
    bus.cks_ready_i = 1'b0;
    set_job(32'h0, 32'h0, 32'h0);

    // Reset state
    step();
    step();
    check1 ("rst_ready", bus.job_ready_o, 1'b1);
    check1 ("rst_start", bus.cks_start_o, 1'b0);
    check1 ("rst_busy", bus.busy_o, 1'b0);
    check1 ("rst_done", bus.done_o, 1'b0);
    check32("rst_count", 32'(bus.jobs_done_o), 32'd0);
    check1 ("rst_err", bus.err_o, 1'b0);
    rst = 1'b1;
    step();

    // Single job, unit answers 12 cycles after start
    push(32'h100, 32'd20, 32'h10A);
    check1("t1_start_t1", bus.cks_start_o, 1'b0);
    check1("t1_busy", bus.busy_o, 1'b1);
    step();
    check_cks("t1", 32'h100, 32'd20, 32'h10A);
    for (int i = 0; i < 11; i++) begin
      step();
      check_cks($sformatf("t1_hold%0d", i), 32'h100, 32'd20, 32'h10A);
      check1($sformatf("t1_nodone%0d", i), bus.done_o, 1'b0);
    end
    complete("t1");
    step();
    check1("t1_done_once", bus.done_o, 1'b0);
    step();
    check1("t1_idle_busy", bus.busy_o, 1'b0);

    // Five back-to-back jobs into a 4-deep FIFO
    for (int k = 0; k < 5; k++) begin
      jfs[k]  = 32'h200 + 32'(k) * 32'h10;
      jfl[k]  = 32'(k) + 32'd1;
      jdst[k] = 32'h300 + 32'(k);
    end
    for (int k = 0; k < 5; k++) begin
      set_job(jfs[k], jfl[k], jdst[k]);
      bus.job_valid_i = 1'b1;
      check1($sformatf("t2_ready%0d", k), bus.job_ready_o, 1'b1);
      step();
    end
    set_job(32'hDEAD, 32'd99, 32'hBEEF);
    check1("t2_full", bus.job_ready_o, 1'b0);
    step();
    check1("t2_full_hold", bus.job_ready_o, 1'b0);
    bus.job_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("t2_j%0d", k), 10, cyc);
      if (k > 0) check32($sformatf("t2_gap%0d", k), 32'(cyc), 32'd2);
      check_cks($sformatf("t2_j%0d", k), jfs[k], jfl[k], jdst[k]);
      step();
      step();
      step();
      check_cks($sformatf("t2_j%0d_hold", k), jfs[k], jfl[k], jdst[k]);
      complete($sformatf("t2_j%0d", k));
    end
    step();
    check1("t2_drained_busy", bus.busy_o, 1'b0);
    check1("t2_ready_again", bus.job_ready_o, 1'b1);

    // Stale ready held high through ISSUE
    bus.cks_ready_i = 1'b1;
    push(32'h400, 32'd0, 32'h410);
    step();
    check_cks("t3", 32'h400, 32'd0, 32'h410);
    step();
    check1 ("t3_no_issue_done", bus.done_o, 1'b0);
    check1 ("t3_still_start", bus.cks_start_o, 1'b1);
    check32("t3_count_held", 32'(bus.jobs_done_o), 32'(exp_done));
    bus.cks_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check1($sformatf("t3_wait%0d", i), bus.done_o, 1'b0);
    end
    complete("t3");
    step();
    step();

    // Simultaneous push and pop at occupancy 3
    push(32'h500, 32'd5, 32'h5A0);
    push(32'h510, 32'd6, 32'h5B0);
    push(32'h520, 32'd7, 32'h5C0);
    push(32'h530, 32'd8, 32'h5D0);
    check1("t4_occ3_ready", bus.job_ready_o, 1'b1);
    check_cks("t4_a", 32'h500, 32'd5, 32'h5A0);
    complete("t4_a");
    step();
    set_job(32'h540, 32'd9, 32'h5E0);
    bus.job_valid_i = 1'b1;
    step();
    bus.job_valid_i = 1'b0;
    check1("t4_pushpop_ready", bus.job_ready_o, 1'b1);
    check_cks("t4_b", 32'h510, 32'd6, 32'h5B0);
    push(32'h550, 32'd10, 32'h5F0);
    check1("t4_occ4_full", bus.job_ready_o, 1'b0);
    for (int k = 1; k < 6; k++) begin
      wait_start($sformatf("t4_d%0d", k), 10, cyc);
      check_cks($sformatf("t4_d%0d", k), 32'h500 + 32'(k) * 32'h10, 32'd5 + 32'(k),
                32'h5A0 + 32'(k) * 32'h10);
      step();
      complete($sformatf("t4_d%0d", k));
    end
    step();
    check1("t4_drained_busy", bus.busy_o, 1'b0);
    check1("t4_err", bus.err_o, exp_err);

`ifdef CKSUM_DISPATCH_TIMEOUT_EN
    // Unit never readies: timeout after 8 WAIT cycles, next job still issues
    push(32'h600, 32'd3, 32'h6A0);
    push(32'h610, 32'd4, 32'h6B0);
    check_cks("t5_x", 32'h600, 32'd3, 32'h6A0);
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      check1($sformatf("t5_wait%0d", i), bus.cks_start_o, 1'b1);
    end
    step();
    exp_err = 1'b1;
    check1 ("t5_drop", bus.cks_start_o, 1'b0);
    check1 ("t5_err", bus.err_o, exp_err);
    check1 ("t5_no_done", bus.done_o, 1'b0);
    check32("t5_count", 32'(bus.jobs_done_o), 32'(exp_done));
    $display("job t5_x timeout start=%b err=%b", bus.cks_start_o, bus.err_o);
    wait_start("t5_y", 10, cyc);
    check_cks("t5_y", 32'h610, 32'd4, 32'h6B0);
    step();
    complete("t5_y");
    check1("t5_err_sticky", bus.err_o, exp_err);
    step();
    step();
`endif

    // Reset in the middle of a job with more queued
    push(32'h700, 32'd1, 32'h7A0);
    push(32'h710, 32'd2, 32'h7B0);
    push(32'h720, 32'd3, 32'h7C0);
    step();
    check_cks("t6_pre", 32'h700, 32'd1, 32'h7A0);
    rst = 1'b0;
    step();
    exp_done = 0;
    exp_err  = 1'b0;
    check1 ("t6_start", bus.cks_start_o, 1'b0);
    check1 ("t6_busy", bus.busy_o, 1'b0);
    check32("t6_count", 32'(bus.jobs_done_o), 32'(exp_done));
    check1 ("t6_ready", bus.job_ready_o, 1'b1);
    check1 ("t6_err", bus.err_o, exp_err);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check1($sformatf("t6_quiet%0d", i), bus.cks_start_o, 1'b0);
    end
    check1("t6_quiet_busy", bus.busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
